rc522_cmd_sequencer: RTL

//  Table-driven command sequencer for the RC522 reader over the SPI byte master.

---
 rtl/rc522_cmd_sequencer_if.sv | 25 ++
 rtl/rc522_cmd_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rc522_cmd_sequencer_if.sv
// Byte handshake between the RC522 command sequencer and the SPI byte master.
//   master : sequencer side (drives spi_start/spi_tx/spi_hold, receives spi_done/spi_rx)
//   slave  : SPI byte master side
// spi_start  1-cycle request to shift spi_tx out
// spi_tx     byte to send, held stable until spi_done
// spi_hold   keep chip-select asserted between the address and data bytes
// spi_done   1-cycle completion pulse, spi_rx valid alongside it
// spi_rx     byte shifted in during the transfer
interface rc522_cmd_sequencer_if;
  logic       spi_start;
  logic [7:0] spi_tx;
  logic       spi_hold;
  logic       spi_done;
  logic [7:0] spi_rx;

  modport master (
    output spi_start, spi_tx, spi_hold,
    input  spi_done, spi_rx
  );

  modport slave (
    input  spi_start, spi_tx, spi_hold,
    output spi_done, spi_rx
  );
endinterface

// File: rtl/rc522_cmd_sequencer.sv
// Purpose : walks a command table and turns each entry into RC522 register
//           writes/reads (address byte + data byte) or a timed delay.
// Latency : 2 clk fetch/decode + 2 SPI bytes + 1 clk per access entry; WAIT
//           entries take data*WAIT_UNIT clk (min 1).
// Backpr. : each byte waits on spi_done; no spi_done within TIMEOUT clk of
//           spi_start aborts the run with a sticky error.
// Ports   : clk/rst, start+base_addr (run request), tbl_addr/tbl_data
//           (synchronous table read, 1 clk latency), spi (byte handshake),
//           rd_valid/rd_addr/rd_data (read results), busy/done/error (status).
module rc522_cmd_sequencer #(
  parameter int TBL_AW    = 5,
  parameter int TIMEOUT   = 1024,
  parameter int WAIT_UNIT = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TBL_AW-1:0]     base_addr,
  output logic [TBL_AW-1:0]     tbl_addr,
  input  logic [15:0]           tbl_data,
  rc522_cmd_sequencer_if.master spi,
  output logic                  rd_valid,
  output logic [5:0]            rd_addr,
  output logic [7:0]            rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(255 * WAIT_UNIT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WAIT  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ADDR_TX, S_ADDR_WT,
    S_DATA_TX, S_DATA_WT, S_NEXT, S_DELAY, S_DONE
  } state_t;

  state_t          state;
  logic            is_rd;
  logic [5:0]      ent_addr;
  logic [7:0]      ent_data;
  logic [TW-1:0]   tmo_cnt;
  logic [DW-1:0]   dly_cnt;

  // tbl_addr doubles as the table pointer: it is already registered and the
  // table returns the entry one clock after it settles in FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      tbl_addr      <= '0;
      is_rd         <= 1'b0;
      ent_addr      <= '0;
      ent_data      <= '0;
      tmo_cnt       <= '0;
      dly_cnt       <= '0;
      spi.spi_start <= 1'b0;
      spi.spi_tx    <= '0;
      spi.spi_hold  <= 1'b0;
      rd_valid      <= 1'b0;
      rd_addr       <= '0;
      rd_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      spi.spi_start <= 1'b0;
      rd_valid      <= 1'b0;
      done          <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            tbl_addr <= base_addr;
            busy     <= 1'b1;
            error    <= 1'b0;
            state    <= S_FETCH;
          end
        end

        S_FETCH: state <= S_DECODE;

        S_DECODE: begin
          is_rd    <= (tbl_data[15:14] == OP_READ);
          ent_addr <= tbl_data[13:8];
          ent_data <= tbl_data[7:0];
          case (tbl_data[15:14])
            OP_WRITE, OP_READ: begin
              // Address byte: bit7 = read flag, bits6:1 = register, bit0 = 0.
              spi.spi_start <= 1'b1;
              spi.spi_tx    <= {tbl_data[14], tbl_data[13:8], 1'b0};
              spi.spi_hold  <= 1'b1;
              state         <= S_ADDR_TX;
            end
            OP_WAIT: begin
              dly_cnt <= (tbl_data[7:0] == 8'd0) ? DW'(1)
                                                 : DW'(tbl_data[7:0]) * DW'(WAIT_UNIT);
              state   <= S_DELAY;
            end
            default: begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          endcase
        end

        // tmo_cnt holds the number of clocks elapsed since the last spi_start.
        S_ADDR_TX: begin
          tmo_cnt <= TW'(1);
          state   <= S_ADDR_WT;
        end

        S_DATA_TX: begin
          tmo_cnt <= TW'(1);
          state   <= S_DATA_WT;
        end

        S_ADDR_WT, S_DATA_WT: begin
          if (spi.spi_done) begin
            if (state == S_ADDR_WT) begin
              // A read clocks out a dummy byte while the register value comes back.
              spi.spi_start <= 1'b1;
              spi.spi_tx    <= is_rd ? 8'h00 : ent_data;
              state         <= S_DATA_TX;
            end else begin
              spi.spi_hold <= 1'b0;
              if (is_rd) begin
                rd_valid <= 1'b1;
                rd_addr  <= ent_addr;
                rd_data  <= spi.spi_rx;
              end
              state <= S_NEXT;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            // Error becomes visible exactly TIMEOUT clocks after spi_start.
            error        <= 1'b1;
            busy         <= 1'b0;
            spi.spi_hold <= 1'b0;
            state        <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        S_DELAY: begin
          if (dly_cnt <= DW'(1)) state <= S_NEXT;
          else                   dly_cnt <= dly_cnt - DW'(1);
        end

        // Pointer wraps naturally at 2**TBL_AW; a table with no END keeps running.
        S_NEXT: begin
          tbl_addr <= tbl_addr + TBL_AW'(1);
          state    <= S_FETCH;
        end

        // start is deliberately not looked at here, so a start coinciding with
        // the done pulse is dropped.
        S_DONE:  state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
